pipeline_fetch: RTL and testbench

Instruction fetch unit that feeds the `instruction` byte into pipeline stage 1. It owns the program counter and issues byte reads on the memory bus. A small prefetch FIFO decouples the reads from the instruction stream.
- Honours stage 1's `fetch_suppress_out` by injecting NOP (0x00).
- Yields the bus to an external master on `bus_request`.
- Redirects the PC on a `pc_load` from the branch/transfer logic.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/pipeline_fetch.sv | 146 ++++++++++++++
 tb/tb_pipeline_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction fetch unit.
package pipeline_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    YIELD = 2'd2
  } fetch_state_t;

  localparam logic [7:0]  NOP_OPCODE           = 8'h00;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous, power-of-two depth, flush overrides push/pop.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok  = push && !flush && (!full || pop_ok);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (!push_ok && pop_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch unit: owns the PC, issues byte reads, feeds stage 1 via a prefetch FIFO.
// Optional macro FETCH_PC_TRACE_EN adds the instr_pc output and per-entry address storage.
//
// state | meaning
// FETCH | idle on the bus; issue a read when a FIFO slot is free
// WAIT  | read outstanding, mem_req held until mem_ack
// YIELD | bus released to the external master
module pipeline_fetch
  import pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_suppress,
  input  logic                  bus_request,
  output logic                  bus_grant,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_data,
`ifdef FETCH_PC_TRACE_EN
  output logic [ADDR_WIDTH-1:0] instr_pc,
`endif
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef FETCH_PC_TRACE_EN
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
`else
  localparam int EW = DATA_WIDTH;
`endif

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  discard;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [EW-1:0]         push_entry;
  logic [EW-1:0]         head_entry;
  logic                  slot_free;

  // No read is outstanding while in FETCH, so occupancy alone decides.
  assign slot_free  = fifo_count < DEPTH_C;
  assign fifo_pop   = !pc_load && !fetch_suppress && !fifo_empty;
  assign fifo_push  = (state == WAIT) && mem_ack && !discard && !pc_load;
`ifdef FETCH_PC_TRACE_EN
  assign push_entry = {mem_addr, mem_data};
`else
  assign push_entry = mem_data;
`endif

  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push && (!fifo_full || fifo_pop)),
    .data_in  (push_entry),
    .pop      (fifo_pop),
    .flush    (pc_load),
    .data_out (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      pc        <= RESET_VECTOR;
      discard   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      bus_grant <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (pc_load) pc <= pc_load_value;
          if (bus_request) begin
            state <= YIELD;
          end else if (!pc_load && slot_free) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            discard <= 1'b0;
            // A redirected read leaves pc on the target rather than advancing it.
            if (pc_load)      pc <= pc_load_value;
            else if (!discard) pc <= pc + ADDR_WIDTH'(1);
            state <= bus_request ? YIELD : FETCH;
          end else if (pc_load) begin
            pc      <= pc_load_value;
            discard <= 1'b1;
          end
        end
        YIELD: begin
          if (pc_load) pc <= pc_load_value;
          if (bus_request) begin
            bus_grant <= 1'b1;
          end else begin
            bus_grant <= 1'b0;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instruction <= DATA_WIDTH'(NOP_OPCODE);
      instr_valid <= 1'b0;
`ifdef FETCH_PC_TRACE_EN
      instr_pc    <= '0;
`endif
    end else if (pc_load || fetch_suppress || fifo_empty) begin
      instruction <= DATA_WIDTH'(NOP_OPCODE);
      instr_valid <= 1'b0;
`ifdef FETCH_PC_TRACE_EN
      instr_pc    <= '0;
`endif
    end else begin
      instruction <= head_entry[DATA_WIDTH-1:0];
      instr_valid <= 1'b1;
`ifdef FETCH_PC_TRACE_EN
      instr_pc    <= head_entry[EW-1:DATA_WIDTH];
`endif
    end
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Scoreboard bench for pipeline_fetch: address-stream reference model plus directed scenarios.
module tb_pipeline_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_suppress = 1'b0;
  logic        bus_request = 1'b0;
  logic        bus_grant;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  instruction;
  logic        instr_valid;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mem_latency = 0;
  int wait_cnt = 0;
  int valid_seen = 0;
  bit force_ack = 1'b0;
  bit tracked = 1'b0;
  logic [15:0] req_ptr = 16'h0100;
  logic [7:0]  exp_q [$];

  pipeline_fetch #(.RESET_VECTOR(16'h0100)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_suppress (fetch_suppress),
    .bus_request    (bus_request),
    .bus_grant      (bus_grant),
    .pc_load        (pc_load),
    .pc_load_value  (pc_load_value),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .instruction    (instruction),
    .instr_valid    (instr_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] + 8'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_new_req(input string name);
    int n = 0;
    while (mem_req && n < 40) begin @(posedge clk); #1; n++; end
    while (!mem_req && n < 40) begin @(posedge clk); #1; n++; end
    if (!mem_req) begin
      total_cnt++;
      $display("FAIL %s: got no mem_req expected a new request within 40 cycles", name);
    end
  endtask

  // Memory responder: acks after mem_latency extra cycles with addr[7:0]+1.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack = 1'b1;
    end else if (reset_n && mem_req) begin
      if (wait_cnt >= mem_latency) begin
        mem_ack  = 1'b1;
        mem_data = memf(mem_addr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Reference model: reads go out in PC order; a redirect drops every byte not yet delivered.
  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      req_ptr = 16'h0100;
      tracked = 1'b0;
    end else begin
      if (mem_req && !tracked) begin
        check("mem_addr", 32'(mem_addr), 32'(req_ptr));
        exp_q.push_back(memf(req_ptr));
        req_ptr++;
        tracked = 1'b1;
      end
      if (mem_req && mem_ack) tracked = 1'b0;
      if (pc_load) begin
        exp_q.delete();
        req_ptr = pc_load_value;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (reset_n && instr_valid) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL instr_unexpected: got %0h expected no valid byte", instruction);
      end else begin
        e = exp_q.pop_front();
        check("instruction", 32'(instruction), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int vs;
    bit got;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_bus_grant", 32'(bus_grant), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", 32'(mem_addr), 32'h0100);
    for (int i = 1; i < 3; i++) begin
      wait_new_req("seq");
      check("seq_addr", 32'(mem_addr), 32'h0100 + 32'(i));
    end

    fetch_suppress = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("suppress_valid", 32'(instr_valid), 32'd0);
      check("suppress_instr", 32'(instruction), 32'd0);
    end
    fetch_suppress = 1'b0;

    mem_latency = 3;
    n = 0;
    while (!(mem_req && mem_addr == 16'h0105) && n < 80) begin @(posedge clk); #1; n++; end
    if (!(mem_req && mem_addr == 16'h0105)) begin
      total_cnt++;
      $display("FAIL find_0105: got addr %0h expected a read to 0105", mem_addr);
    end
    pc_load = 1'b1;
    pc_load_value = 16'h2000;
    @(posedge clk); #1;
    pc_load = 1'b0;
    check("flush_valid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    check("flush_empty", 32'(instr_valid), 32'd0);
    wait_new_req("redirect");
    check("redirect_addr", 32'(mem_addr), 32'h2000);

    bus_request = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(posedge clk);
      got = mem_ack;
      #1;
      if (!got) check("hold_req", 32'(mem_req), 32'd1);
      n++;
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL bus_ack: got no mem_ack expected one within 10 cycles");
    end
    check("drop_req", 32'(mem_req), 32'd0);
    check("grant_entry", 32'(bus_grant), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("grant", 32'(bus_grant), 32'd1);
      check("yield_req", 32'(mem_req), 32'd0);
    end
    bus_request = 1'b0;
    @(posedge clk); #1;
    check("grant_off", 32'(bus_grant), 32'd0);
    @(posedge clk); #1;
    check("resume_req", 32'(mem_req), 32'd1);
    check("resume_addr", 32'(mem_addr), 32'h2001);

    mem_latency = 0;
    pc_load = 1'b1;
    pc_load_value = 16'hFFFF;
    @(posedge clk); #1;
    pc_load = 1'b0;
    wait_new_req("wrap_a");
    check("wrap_ffff", 32'(mem_addr), 32'hFFFF);
    wait_new_req("wrap_b");
    check("wrap_0000", 32'(mem_addr), 32'h0000);

    repeat (800) begin
      @(posedge clk); #1;
      mem_latency    = int'($urandom_range(0, 3));
      fetch_suppress = ($urandom_range(0, 99) < 20);
      pc_load        = ($urandom_range(0, 99) < 3);
      pc_load_value  = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'hFFFE;
      if (bus_request) bus_request = ($urandom_range(0, 3) != 0);
      else             bus_request = ($urandom_range(0, 99) < 5);
    end

    @(posedge clk); #1;
    fetch_suppress = 1'b0;
    pc_load = 1'b0;
    bus_request = 1'b0;
    mem_latency = 0;
    vs = valid_seen;
    repeat (30) @(posedge clk);
    #1;
    check("drain_live", 32'((valid_seen - vs) >= 8), 32'd1);
    check("drain_depth", 32'(exp_q.size() <= 3), 32'd1);

    mem_latency = 3;
    wait_new_req("rst_wait");
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_bus_grant", 32'(bus_grant), 32'd0);
    check("arst_instruction", 32'(instruction), 32'd0);
    check("arst_instr_valid", 32'(instr_valid), 32'd0);
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_ack = 1'b0;
    mem_latency = 0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req", 32'(mem_req), 32'd1);
    check("post_rst_addr", 32'(mem_addr), 32'h0100);
    repeat (20) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
